// File: rtl/switch_input_ctrl.sv
// Switch/button input front end: synchronises SW and the enter button, debounces the button,
// captures the switch word per press and hands it over with valid/ack. Option: SWIN_DEBOUNCE_BYPASS_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | button released and stable, waiting for a press
// PRESS    | button seen high, counting stable-high cycles
// WAIT_REL | press accepted, waiting for the button to go low
// RELEASE  | button seen low, counting stable-low cycles
module switch_input_ctrl #(
  parameter int N               = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw_raw,
  input  logic         btn_raw,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ack,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS    = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic capture;

  logic [SYNC_STAGES-1:0]        btn_sync;
  logic [SYNC_STAGES-1:0][N-1:0] sw_sync;
  logic                          btn_s;
  logic [N-1:0]                  sw_s;

  // Switch and button chains have equal depth so sw_s lines up with the press that captures it.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync <= '0;
      sw_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_raw};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign btn_s = btn_sync[SYNC_STAGES-1];
  assign sw_s  = sw_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
`ifdef SWIN_DEBOUNCE_BYPASS_EN
    cnt_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (btn_s) begin
          capture   = 1'b1;
          state_nxt = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!btn_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
`else
    case (state)
      ST_IDLE: begin
        if (btn_s) begin
          state_nxt = ST_PRESS;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_PRESS: begin
        if (!btn_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          capture   = 1'b1;
          state_nxt = ST_WAIT_REL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_WAIT_REL: begin
        if (!btn_s) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (btn_s) begin
          state_nxt = ST_WAIT_REL;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
`endif
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  // A capture that coincides with an ack replaces the word instead of flagging overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (capture) begin
      if (!data_valid || data_ack) begin
        data_out   <= sw_s;
        data_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (data_ack && data_valid) begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Bench for switch_input_ctrl: run-length reference model, scoreboard of presented words,
// directed scenarios followed by randomized button/switch/ack traffic.
module tb_switch_input_ctrl;
  localparam int N  = 8;
  localparam int SS = 2;
  localparam int D  = 16;
`ifdef SWIN_DEBOUNCE_BYPASS_EN
  localparam int DEFF = 1;
`else
  localparam int DEFF = D;
`endif
  localparam int LAT = SS + DEFF;

  logic         clk;
  logic         reset;
  logic [N-1:0] sw_raw;
  logic         btn_raw;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         data_ack;
  logic         overrun;
  logic         busy;

  switch_input_ctrl #(.N(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
    .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the button is a sequence of synchronised samples; a press is DEFF
  // consecutive highs while armed, re-arming needs DEFF consecutive lows.
  logic         m_btn_p [SS];
  logic [N-1:0] m_sw_p  [SS];
  bit           m_armed = 1'b1;
  int           m_run   = 0;
  bit           m_valid = 1'b0;
  bit           m_ovr   = 1'b0;
  logic [N-1:0] m_data  = '0;
  bit           m_ack_edge = 1'b0;
  logic [N-1:0] exp_q[$];
  bit           bs, cap;
  logic [N-1:0] ss;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SS; i++) begin
        m_btn_p[i] = 1'b0;
        m_sw_p[i]  = '0;
      end
      m_armed = 1'b1; m_run = 0; m_valid = 1'b0; m_ovr = 1'b0;
      m_data = '0; m_ack_edge = 1'b0;
    end else begin
      bs  = m_btn_p[SS-1];
      ss  = m_sw_p[SS-1];
      cap = 1'b0;
      if (bs == m_armed) begin
        m_run++;
        if (m_run == DEFF) begin
          cap     = m_armed;
          m_armed = !m_armed;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_ack_edge = data_ack;
      if (cap) begin
        if (!m_valid || data_ack) begin
          m_data  = ss;
          m_valid = 1'b1;
          exp_q.push_back(ss);
        end else begin
          m_ovr = 1'b1;
        end
      end else if (data_ack && m_valid) begin
        m_valid = 1'b0;
      end
      for (int i = SS-1; i > 0; i--) begin
        m_btn_p[i] = m_btn_p[i-1];
        m_sw_p[i]  = m_sw_p[i-1];
      end
      m_btn_p[0] = btn_raw;
      m_sw_p[0]  = sw_raw;
    end
  end

  // Monitor: a word is presented when valid rises, or stays high across an accepted ack.
  bit           prev_dv = 1'b0;
  logic [N-1:0] e_word;

  always @(negedge clk) begin
    check("valid", data_valid, m_valid);
    check("overrun", overrun, m_ovr);
    check("busy", busy, (!m_armed || m_run > 0));
    check("data", data_out, m_data);
    if (data_valid && (!prev_dv || m_ack_edge)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word: got %0h with no expected word pending at %0t", data_out, $time);
      end else begin
        e_word = exp_q.pop_front();
        check("word", data_out, e_word);
      end
    end
    prev_dv = data_valid;
  end

  task automatic run(input logic b, input int n);
    btn_raw = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      sw_raw   = N'($urandom);
      btn_raw  = 1'($urandom);
      data_ack = 1'($urandom);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", data_valid, 0);
      check("rst_data", data_out, 0);
      check("rst_ovr", overrun, 0);
    end
    reset = 1'b0; btn_raw = 1'b0; data_ack = 1'b0;
  endtask

  int remaining;

  initial begin
    reset = 1'b1; sw_raw = '0; btn_raw = 1'b0; data_ack = 1'b0;
    do_reset(3);

    // Held press: latency and single capture
    sw_raw  = 8'hA5;
    btn_raw = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == LAT - 1) check("lat_early", data_valid, 0);
      if (i == LAT) begin
        check("lat_valid", data_valid, 1);
        check("lat_data", data_out, 8'hA5);
      end
    end
    check("a5_ovr", overrun, 0);
    run(1'b0, D + 8);
    ack_pulse();
    check("a5_ack_valid", data_valid, 0);
    check("a5_ack_data", data_out, 8'hA5);

    // Short glitch
    sw_raw = 8'h77;
    run(1'b1, 10);
    run(1'b0, 10);
    check("glitch_valid", data_valid, (10 >= DEFF));
    check("glitch_busy", busy, 0);
    if (data_valid) ack_pulse();
    run(1'b0, D + 4);

    // Overrun: second press with the first word still pending
    sw_raw = 8'h3C;
    run(1'b1, LAT + 4);
    run(1'b0, 20);
    sw_raw = 8'hFF;
    run(1'b1, LAT + 4);
    check("ovr_flag", overrun, 1);
    check("ovr_data", data_out, 8'h3C);
    check("ovr_valid", data_valid, 1);
    ack_pulse();
    check("ovr_ack_valid", data_valid, 0);
    check("ovr_sticky", overrun, 1);
    run(1'b0, 20);
    check("ovr_sticky2", overrun, 1);
    do_reset(2);

    // Ack on the same edge as the second capture
    sw_raw = 8'h11;
    run(1'b1, LAT + 2);
    run(1'b0, 20);
    sw_raw  = 8'h22;
    btn_raw = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("align_data", data_out, 8'h22);
    check("align_valid", data_valid, 1);
    check("align_ovr", overrun, 0);
    run(1'b1, 5);
    run(1'b0, 20);
    ack_pulse();

    // Release bounce
    sw_raw = 8'h5A;
    run(1'b1, LAT + 4);
    run(1'b0, 5);
    run(1'b1, 3);
    btn_raw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == LAT - 1) check("bounce_busy_hi", busy, 1);
      if (i == LAT) check("bounce_busy_lo", busy, 0);
    end
    check("bounce_data", data_out, 8'h5A);
    ack_pulse();

    // Randomized traffic
    remaining = 1;
    for (int c = 0; c < 4000; c++) begin
      remaining--;
      if (remaining <= 0) begin
        btn_raw   = ~btn_raw;
        remaining = $urandom_range(1, 2 * D + 4);
        if ($urandom_range(0, 1) == 0) sw_raw = N'($urandom);
      end
      if ($urandom_range(0, 15) == 0) sw_raw = N'($urandom);
      data_ack = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0; data_ack = 1'b0;
    run(1'b0, D + 6);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
